// File: rtl/key_cnt_pkg.sv
// Shared types and default sizes for the key index counter.
package key_cnt_pkg;

  typedef enum logic {
    CNT_WRAP    = 1'b0,
    CNT_ONESHOT = 1'b1
  } cnt_mode_t;

  localparam int DEF_WIDTH       = 2;
  localparam int DEF_EPOCH_WIDTH = 8;

endpackage

// File: rtl/key_epoch_sat.sv
// Saturating wrap counter: counts increment strobes, sticks at all-ones.
module key_epoch_sat
  import key_cnt_pkg::*;
#(
  parameter int EPOCH_WIDTH = DEF_EPOCH_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   inc_i,
  output logic [EPOCH_WIDTH-1:0] epoch_o
);

  logic [EPOCH_WIDTH-1:0] epoch_q;
  logic [EPOCH_WIDTH-1:0] epoch_d;

  always_comb begin
    epoch_d = epoch_q;
    if (clr_i) begin
      epoch_d = '0;
    end else if (inc_i && (epoch_q != '1)) begin
      epoch_d = epoch_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      epoch_q <= '0;
    end else begin
      epoch_q <= epoch_d;
    end
  end

  assign epoch_o = epoch_q;

endmodule

// File: rtl/key_index_counter.sv
// Key/round index counter with programmable terminal, wrap/one-shot
// modes, wrap strobe and saturating epoch count.
module key_index_counter
  import key_cnt_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int EPOCH_WIDTH = DEF_EPOCH_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   load_en,
  input  logic [WIDTH-1:0]       load_val,
  input  logic                   count_enable,
  input  logic [WIDTH-1:0]       rollover_val,
  input  logic                   mode,
  output logic [WIDTH-1:0]       key_count,
  output logic                   key_rollover,
  output logic                   wrap_pulse,
  output logic [EPOCH_WIDTH-1:0] epoch,
  output logic                   done
);

  cnt_mode_t        mode_e;
  logic [WIDTH-1:0] count_q, count_d;
  logic             roll_q, roll_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             at_term;
  logic             stalled;
  logic             epoch_inc;

  assign mode_e  = cnt_mode_t'(mode);
  assign at_term = (count_q >= rollover_val);
  // A finished one-shot ignores enables until clear/load.
  assign stalled = (mode_e == CNT_ONESHOT) && done_q;

  always_comb begin
    count_d   = count_q;
    done_d    = done_q;
    wrap_d    = 1'b0;
    epoch_inc = 1'b0;
    if (clear) begin
      count_d = '0;
      done_d  = 1'b0;
    end else if (load_en) begin
      count_d = load_val;
      done_d  = 1'b0;
    end else if (count_enable && !stalled) begin
      if (!at_term) begin
        count_d = count_q + 1'b1;
      end else if (mode_e == CNT_ONESHOT) begin
        done_d = 1'b1;
      end else begin
        count_d   = '0;
        wrap_d    = 1'b1;
        epoch_inc = 1'b1;
      end
    end
    roll_d = (count_d >= rollover_val);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      roll_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      roll_q  <= roll_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  key_epoch_sat #(
    .EPOCH_WIDTH(EPOCH_WIDTH)
  ) u_epoch (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clear),
    .inc_i  (epoch_inc),
    .epoch_o(epoch)
  );

  assign key_count    = count_q;
  assign key_rollover = roll_q;
  assign wrap_pulse   = wrap_q;
  assign done         = done_q;

endmodule
